// File: rtl/envelope_pkg.sv
// envelope_pkg: shared types and constants for the per-voice envelope shaper.
//   env_state_t : envelope phase (IDLE / ATTACK / SUSTAIN / RELEASE)
//   ENV_W       : level and sample width
//   MUL_CYCLES  : cycles the shift-add multiplier takes from start to done
//   MIDPOINT    : sample midpoint used by the centered scaling build
package envelope_pkg;

  localparam int ENV_W      = 8;
  localparam int MUL_CYCLES = 8;

  localparam logic [ENV_W-1:0] MIDPOINT = 8'd128;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ATTACK  = 2'd1,
    ST_SUSTAIN = 2'd2,
    ST_RELEASE = 2'd3
  } env_state_t;

endpackage

// File: rtl/shift_add_mul.sv
// shift_add_mul: 8x8 unsigned shift-add multiplier.
//   clk, reset : clock and synchronous active-high reset (aborts a run)
//   start      : one-cycle pulse; a and b are sampled on this edge
//   a, b       : multiplicand and multiplier
//   busy       : high while the remaining partial products are accumulated
//   product    : 16-bit result, held until the next run completes
//   done       : one-cycle pulse, first visible MUL_CYCLES cycles after start
// Bit 0 of b is consumed on the start edge itself, bits 1..7 on the following
// seven edges, so the result lands exactly MUL_CYCLES cycles after start.
module shift_add_mul
  import envelope_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ENV_W-1:0]     a,
  input  logic [ENV_W-1:0]     b,
  output logic                 busy,
  output logic [2*ENV_W-1:0]   product,
  output logic                 done
);

  localparam int CNT_W = $clog2(MUL_CYCLES);

  logic [2*ENV_W-1:0] mcand_r;
  logic [2*ENV_W-1:0] acc_r;
  logic [2*ENV_W-1:0] product_r;
  logic [ENV_W-1:0]   mplier_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               busy_r;
  logic               done_r;
  logic [2*ENV_W-1:0] partial_s;
  logic [2*ENV_W-1:0] acc_next_s;

  // Partial product for the multiplier bit currently at the LSB
  always_comb begin
    if (mplier_r[0]) begin
      partial_s = mcand_r;
    end else begin
      partial_s = {(2*ENV_W){1'b0}};
    end
    acc_next_s = acc_r + partial_s;
  end

  // Operand capture, per-bit accumulation and completion pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_r   <= {(2*ENV_W){1'b0}};
      acc_r     <= {(2*ENV_W){1'b0}};
      product_r <= {(2*ENV_W){1'b0}};
      mplier_r  <= {ENV_W{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else if (start) begin
      acc_r    <= b[0] ? {{ENV_W{1'b0}}, a} : {(2*ENV_W){1'b0}};
      mcand_r  <= {{(ENV_W-1){1'b0}}, a, 1'b0};
      mplier_r <= {1'b0, b[ENV_W-1:1]};
      cnt_r    <= CNT_W'(1);
      busy_r   <= 1'b1;
      done_r   <= 1'b0;
    end else if (busy_r) begin
      acc_r    <= acc_next_s;
      mcand_r  <= {mcand_r[2*ENV_W-2:0], 1'b0};
      mplier_r <= {1'b0, mplier_r[ENV_W-1:1]};
      cnt_r    <= cnt_r + CNT_W'(1);
      if (cnt_r == CNT_W'(MUL_CYCLES - 1)) begin
        product_r <= acc_next_s;
        busy_r    <= 1'b0;
        done_r    <= 1'b1;
      end else begin
        done_r    <= 1'b0;
      end
    end else begin
      done_r <= 1'b0;
    end
  end

  assign busy    = busy_r;
  assign product = product_r;
  assign done    = done_r;

endmodule

// File: rtl/envelope_shaper.sv
// envelope_shaper: per-voice attack/release envelope and sample scaler.
//   ATK_STEP / REL_STEP : level change per accepted strobe in ATTACK / RELEASE
//   clk, reset          : clock and synchronous active-high reset
//   key                 : voice gate, 1 = held (sampled only on accepted strobes)
//   sample_now          : sample-rate strobe; ignored while a multiply runs
//   sample_in           : unsigned waveshaper sample
//   sample_out          : scaled sample, held between updates
//   done                : one-cycle pulse when sample_out updates (strobe + 9)
//   active              : 1 whenever the envelope is not IDLE
// Build option: define ENVELOPE_CENTER_EN to scale about the midpoint 128
// instead of about zero (sample_out then resets to 128).
module envelope_shaper
  import envelope_pkg::*;
#(
  parameter int ATK_STEP = 4,
  parameter int REL_STEP = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             key,
  input  logic             sample_now,
  input  logic [ENV_W-1:0] sample_in,
  output logic [ENV_W-1:0] sample_out,
  output logic             done,
  output logic             active
);

  localparam logic [ENV_W:0]   ATK_V = (ENV_W+1)'(ATK_STEP);
  localparam logic [ENV_W-1:0] REL_V = ENV_W'(REL_STEP);
  localparam logic [ENV_W-1:0] LVL_MAX = 8'd255;
`ifdef ENVELOPE_CENTER_EN
  localparam logic [ENV_W-1:0] OUT_RESET = MIDPOINT;
`else
  localparam logic [ENV_W-1:0] OUT_RESET = 8'd0;
`endif

  env_state_t           state_r;
  env_state_t           state_next_s;
  logic [ENV_W-1:0]     level_r;
  logic [ENV_W-1:0]     level_next_s;
  logic [ENV_W:0]       sum_s;
  logic                 busy_r;
  logic                 accept_s;
  logic                 active_r;
  logic [ENV_W-1:0]     sample_out_r;
  logic                 done_r;
  logic [ENV_W-1:0]     mul_a_s;
  logic                 mul_busy_s;
  logic [2*ENV_W-1:0]   mul_product_s;
  logic                 mul_done_s;
  logic [2*ENV_W-1:0]   prod_signed_s;
  logic [ENV_W-1:0]     out_next_s;
  logic [ENV_W-1:0]     prod_lo_unused_s;
`ifdef ENVELOPE_CENTER_EN
  logic [ENV_W:0]       diff_s;
  logic                 neg_r;
`endif

  assign accept_s = sample_now & ~(busy_r | mul_busy_s);

  // Envelope next state and level; only an accepted strobe moves anything
  always_comb begin
    state_next_s = state_r;
    level_next_s = level_r;
    sum_s        = {1'b0, level_r} + ATK_V;
    if (accept_s) begin
      case (state_r)
        ST_IDLE, ST_ATTACK, ST_RELEASE: begin
          if (key) begin
            // ATTACK saturates into SUSTAIN; a retrigger from RELEASE
            // re-enters ATTACK and only clamps the level
            if (sum_s >= {1'b0, LVL_MAX}) begin
              level_next_s = LVL_MAX;
              state_next_s = (state_r == ST_ATTACK) ? ST_SUSTAIN : ST_ATTACK;
            end else begin
              level_next_s = sum_s[ENV_W-1:0];
              state_next_s = ST_ATTACK;
            end
          end else if (level_r <= REL_V) begin
            level_next_s = {ENV_W{1'b0}};
            state_next_s = ST_IDLE;
          end else begin
            level_next_s = level_r - REL_V;
            state_next_s = ST_RELEASE;
          end
        end
        ST_SUSTAIN: begin
          if (key) begin
            level_next_s = LVL_MAX;
            state_next_s = ST_SUSTAIN;
          end else begin
            level_next_s = LVL_MAX - REL_V;
            state_next_s = ST_RELEASE;
          end
        end
        default: begin
          level_next_s = {ENV_W{1'b0}};
          state_next_s = ST_IDLE;
        end
      endcase
    end else begin
      state_next_s = state_r;
      level_next_s = level_r;
    end
  end

  // Envelope state, level and active flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      level_r  <= {ENV_W{1'b0}};
      active_r <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      level_r  <= level_next_s;
      active_r <= (state_next_s != ST_IDLE);
    end
  end

  // Multiplicand: raw sample, or magnitude of its offset from the midpoint
  always_comb begin
`ifdef ENVELOPE_CENTER_EN
    diff_s = {1'b0, sample_in} - {1'b0, MIDPOINT};
    if (diff_s[ENV_W]) begin
      mul_a_s = 8'd0 - diff_s[ENV_W-1:0];
    end else begin
      mul_a_s = diff_s[ENV_W-1:0];
    end
`else
    mul_a_s = sample_in;
`endif
  end

  shift_add_mul u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (accept_s),
    .a       (mul_a_s),
    .b       (level_next_s),
    .busy    (mul_busy_s),
    .product (mul_product_s),
    .done    (mul_done_s)
  );

  // Strobe lockout from acceptance until the scaled sample is registered
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r <= 1'b0;
    end else if (accept_s) begin
      busy_r <= 1'b1;
    end else if (mul_done_s) begin
      busy_r <= 1'b0;
    end else begin
      busy_r <= busy_r;
    end
  end

`ifdef ENVELOPE_CENTER_EN
  // Sign of the sample offset, held for the duration of the multiply
  always_ff @(posedge clk) begin
    if (reset) begin
      neg_r <= 1'b0;
    end else if (accept_s) begin
      neg_r <= diff_s[ENV_W];
    end else begin
      neg_r <= neg_r;
    end
  end
`endif

  // Product to output sample; bits [15:8] of the two's-complement product
  // equal the floored arithmetic shift by 8
  always_comb begin
`ifdef ENVELOPE_CENTER_EN
    if (neg_r) begin
      prod_signed_s = 16'd0 - mul_product_s;
    end else begin
      prod_signed_s = mul_product_s;
    end
    out_next_s = prod_signed_s[2*ENV_W-1:ENV_W] + MIDPOINT;
`else
    prod_signed_s = mul_product_s;
    out_next_s    = prod_signed_s[2*ENV_W-1:ENV_W];
`endif
    prod_lo_unused_s = prod_signed_s[ENV_W-1:0];
  end

  // Registered scaled sample and its update strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      sample_out_r <= OUT_RESET;
      done_r       <= 1'b0;
    end else begin
      done_r <= mul_done_s;
      if (mul_done_s) begin
        sample_out_r <= out_next_s;
      end else begin
        sample_out_r <= sample_out_r;
      end
    end
  end

  assign sample_out = sample_out_r;
  assign done       = done_r;
  assign active     = active_r;

endmodule

// File: tb/tb_envelope_shaper.sv
// tb_envelope_shaper: directed self-checking bench for envelope_shaper
// (ATK_STEP 4, REL_STEP 2). Expected values follow ENVELOPE_CENTER_EN.
module tb_envelope_shaper;
  import envelope_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       key;
  logic       sample_now;
  logic [7:0] sample_in;
  logic [7:0] sample_out;
  logic       done;
  logic       active;

  int checks = 0;
  int errors = 0;

  // results captured by strobe()
  int         nd;
  int         lat;
  logic [7:0] od;
  logic [7:0] lv1;
  logic [1:0] st1;
  logic       act1;

`ifdef ENVELOPE_CENTER_EN
  localparam logic [7:0] RST_OUT = 8'd128;
`else
  localparam logic [7:0] RST_OUT = 8'd0;
`endif

  always #5 clk = ~clk;

  envelope_shaper #(.ATK_STEP(4), .REL_STEP(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .key        (key),
    .sample_now (sample_now),
    .sample_in  (sample_in),
    .sample_out (sample_out),
    .done       (done),
    .active     (active)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference scaling from the level/sample arithmetic definition
  function automatic logic [7:0] exp_out(input int din, input int lvl);
`ifdef ENVELOPE_CENTER_EN
    int d;
    int p;
    int sp;
    d  = din - 128;
    p  = ((d < 0) ? -d : d) * lvl;
    sp = (d < 0) ? -p : p;
    return 8'((sp >>> 8) + 128);
`else
    return 8'((din * lvl) >> 8);
`endif
  endfunction

  // Strobe at the current cycle T, then watch T+1 .. T+gap-1 and return at T+gap.
  // key toggles between strobes to show it is only sampled on the strobe.
  task automatic strobe(input logic k, input logic [7:0] din, input int gap);
    sample_now = 1'b1;
    key        = k;
    sample_in  = din;
    @(posedge clk); #1;
    sample_now = 1'b0;
    lv1  = dut.level_r;
    st1  = dut.state_r;
    act1 = active;
    nd   = 0;
    lat  = -1;
    od   = 8'd0;
    for (int c = 1; c < gap; c++) begin
      if (done === 1'b1) begin
        nd++;
        if (lat < 0) lat = c;
        od = sample_out;
      end
      key = ~key;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int g;
    int exp_l;
    int nd2;

    reset = 1'b1; key = 1'b0; sample_now = 1'b0; sample_in = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_level",  32'(dut.level_r), 32'd0);
    check("rst_state",  32'(dut.state_r), 32'(ST_IDLE));
    check("rst_active", 32'(active), 32'd0);
    check("rst_done",   32'(done), 32'd0);
    check("rst_out",    32'(sample_out), 32'(RST_OUT));
    reset = 1'b0;
    @(posedge clk); #1;

    // reset in the middle of a multiply
    strobe(1'b1, 8'd200, 4);
    check("pre_rst_level", 32'(lv1), 32'd4);
    check("pre_rst_state", 32'(st1), 32'(ST_ATTACK));
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_state",  32'(dut.state_r), 32'(ST_IDLE));
    check("midrst_level",  32'(dut.level_r), 32'd0);
    check("midrst_active", 32'(active), 32'd0);
    check("midrst_out",    32'(sample_out), 32'(RST_OUT));
    nd2 = 0;
    repeat (12) begin
      if (done === 1'b1) nd2++;
      @(posedge clk); #1;
    end
    check("midrst_no_done", 32'(nd2), 32'd0);

    // attack ramp with a busy-ignore test at k=10 and a 9-cycle spacing at k=20
    for (int k = 1; k <= 64; k++) begin
      g = (k == 10) ? 4 : ((k == 20) ? 9 : 20);
      strobe(1'b1, 8'd200, g);
      exp_l = (4 * k > 255) ? 255 : 4 * k;
      check("atk_level",  32'(lv1), 32'(exp_l));
      check("atk_state",  32'(st1), (k == 64) ? 32'(ST_SUSTAIN) : 32'(ST_ATTACK));
      check("atk_active", 32'(act1), 32'd1);
      if (g == 20) begin
        check("atk_ndone", 32'(nd), 32'd1);
        check("atk_lat",   32'(lat), 32'd9);
        check("atk_out",   32'(od), 32'(exp_out(200, exp_l)));
      end
      if (k == 10) begin
        strobe(1'b0, 8'd200, 16);
        check("busy_level", 32'(lv1), 32'd40);
        check("busy_state", 32'(st1), 32'(ST_ATTACK));
        check("busy_ndone", 32'(nd), 32'd1);
        check("busy_out",   32'(od), 32'(exp_out(200, 40)));
      end
`ifdef ENVELOPE_CENTER_EN
      if (k == 32) check("scale_128_200", 32'(od), 32'd164);
`else
      if (k == 32) check("scale_128_200", 32'(od), 32'd100);
`endif
      if (k == 64) check("scale_255_200", 32'(od), 32'd199);
    end

    // sustain holds; boundary samples at full level
    strobe(1'b1, 8'd0, 20);
    check("sus_level", 32'(lv1), 32'd255);
    check("sus_state", 32'(st1), 32'(ST_SUSTAIN));
    check("scale_255_0", 32'(od), 32'd0);
    strobe(1'b1, 8'd128, 20);
`ifdef ENVELOPE_CENTER_EN
    check("scale_255_128", 32'(od), 32'd128);
`else
    check("scale_255_128", 32'(od), 32'd127);
`endif

    // release ramp down to IDLE
    for (int j = 1; j <= 128; j++) begin
      strobe(1'b0, 8'd200, 20);
      exp_l = (j < 128) ? 255 - 2 * j : 0;
      check("rel_level",  32'(lv1), 32'(exp_l));
      check("rel_state",  32'(st1), (j < 128) ? 32'(ST_RELEASE) : 32'(ST_IDLE));
      check("rel_active", 32'(act1), (j < 128) ? 32'd1 : 32'd0);
      check("rel_out",    32'(od), 32'(exp_out(200, exp_l)));
    end
    strobe(1'b0, 8'd200, 20);
    check("idle_level", 32'(lv1), 32'd0);
    check("idle_state", 32'(st1), 32'(ST_IDLE));

    // retrigger from RELEASE keeps the current level
    for (int k = 0; k < 27; k++) strobe(1'b1, 8'd50, 12);
    check("retrig_peak", 32'(lv1), 32'd108);
    for (int k = 0; k < 4; k++) strobe(1'b0, 8'd50, 12);
    check("retrig_rel_level", 32'(lv1), 32'd100);
    check("retrig_rel_state", 32'(st1), 32'(ST_RELEASE));
    strobe(1'b1, 8'd200, 20);
    check("retrig_level",  32'(lv1), 32'd104);
    check("retrig_state",  32'(st1), 32'(ST_ATTACK));
    check("retrig_active", 32'(act1), 32'd1);
    check("retrig_out",    32'(od), 32'(exp_out(200, 104)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
